// File: rtl/wd_fault_sequencer.sv
// Watchdog fault sequencer: gates and ramps down the RF carrier amplitude when
// the watchdog fires, then holds the transmitter quiet until software clears
// the fault and a holdoff period has elapsed.
module wd_fault_sequencer #(
  parameter int unsigned AMP_W          = 16,
  parameter int unsigned RAMP_STEP      = 256,
  parameter int unsigned HOLDOFF_CYCLES = 1000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wd_triggered,
  input  logic             wd_warning,
  input  logic             clear_fault,
  input  logic [AMP_W-1:0] amp_in,
  output logic [AMP_W-1:0] amp_out,
  output logic             rf_enable,
  output logic             fault_latched,
  output logic [CNT_W-1:0] fault_count,
  output logic [2:0]       state
);

  localparam int unsigned HOLD_W = 24;

  localparam logic [2:0] S_NORMAL    = 3'd0;
  localparam logic [2:0] S_WARN      = 3'd1;
  localparam logic [2:0] S_RAMP_DOWN = 3'd2;
  localparam logic [2:0] S_SAFE      = 3'd3;
  localparam logic [2:0] S_HOLDOFF   = 3'd4;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);
  localparam logic [AMP_W-1:0]  STEP      = AMP_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [2:0]        state_q,  state_d;
  logic [HOLD_W-1:0] hold_q,   hold_d;
  logic [AMP_W-1:0]  amp_q,    amp_d;
  logic              rf_q,     rf_d;
  logic              lat_q,    lat_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              above_step;

  // Saturating increment of the fault counter.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Ramp can take a full step only if it stays strictly above zero.
  assign above_step = (33'(amp_q) > 33'(RAMP_STEP));

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    amp_d   = amp_q;
    rf_d    = rf_q;
    lat_d   = lat_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_NORMAL, S_WARN: begin
        rf_d = 1'b1;
        if (wd_triggered) begin
          // Amplitude freezes on the entry edge; the ramp starts next cycle.
          state_d = S_RAMP_DOWN;
          lat_d   = 1'b1;
          cnt_d   = cnt_inc;
        end else if (wd_warning) begin
          state_d = S_WARN;
          amp_d   = amp_in >> 1;
        end else begin
          state_d = S_NORMAL;
          amp_d   = amp_in;
        end
      end
      S_RAMP_DOWN: begin
        if (above_step) begin
          amp_d = amp_q - STEP;
        end else begin
          amp_d   = '0;
          rf_d    = 1'b0;
          state_d = S_SAFE;
        end
      end
      S_SAFE: begin
        amp_d = '0;
        rf_d  = 1'b0;
        if (clear_fault && !wd_triggered) begin
          state_d = S_HOLDOFF;
          lat_d   = 1'b0;
          hold_d  = '0;
        end
      end
      S_HOLDOFF: begin
        amp_d = '0;
        rf_d  = 1'b0;
        if (wd_triggered) begin
          state_d = S_SAFE;
          lat_d   = 1'b1;
          cnt_d   = cnt_inc;
        end else if (hold_q == HOLD_LAST) begin
          state_d = S_NORMAL;
          rf_d    = 1'b1;
          amp_d   = amp_in;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        // Corrupted encoding: fail safe and flag it, but do not count it.
        state_d = S_SAFE;
        amp_d   = '0;
        rf_d    = 1'b0;
        lat_d   = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset into holdoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_HOLDOFF;
      hold_q  <= '0;
      amp_q   <= '0;
      rf_q    <= 1'b0;
      lat_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      amp_q   <= amp_d;
      rf_q    <= rf_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign amp_out       = amp_q;
  assign rf_enable     = rf_q;
  assign fault_latched = lat_q;
  assign fault_count   = cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_wd_fault_sequencer.sv
// Scoreboard bench for wd_fault_sequencer: the driver queues the hand-computed
// expected outputs for each edge, and a monitor checks them after that edge.
module tb_wd_fault_sequencer;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] amp;
    logic        rf;
    logic        lat;
    logic [1:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wd_triggered = 1'b0;
  logic        wd_warning = 1'b0;
  logic        clear_fault = 1'b0;
  logic [15:0] amp_in = 16'h0000;
  logic [15:0] amp_out;
  logic        rf_enable;
  logic        fault_latched;
  logic [1:0]  fault_count;
  logic [2:0]  state;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_no = 0;

  wd_fault_sequencer #(
    .AMP_W(16), .RAMP_STEP(256), .HOLDOFF_CYCLES(4), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .wd_triggered(wd_triggered), .wd_warning(wd_warning),
    .clear_fault(clear_fault), .amp_in(amp_in), .amp_out(amp_out),
    .rf_enable(rf_enable), .fault_latched(fault_latched),
    .fault_count(fault_count), .state(state)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] st, input logic [15:0] amp,
                              input logic rf, input logic lat, input logic [1:0] cnt);
    exp_t e;
    e.st = st; e.amp = amp; e.rf = rf; e.lat = lat; e.cnt = cnt;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL edge %0d %s: got 0x%0h expected 0x%0h", edge_no, name, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic t, input logic w, input logic c,
                     input logic [15:0] a, input exp_t e);
    @(negedge clk);
    rst = r; wd_triggered = t; wd_warning = w; clear_fault = c; amp_in = a;
    q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare the DUT outputs to the oldest entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        edge_no++;
        chk("state", int'(state), int'(e.st));
        chk("amp_out", int'(amp_out), int'(e.amp));
        chk("rf_enable", int'(rf_enable), int'(e.rf));
        chk("fault_latched", int'(fault_latched), int'(e.lat));
        chk("fault_count", int'(fault_count), int'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-up: reset for two edges, then four holdoff cycles into NORMAL.
    cyc(1, 0, 0, 0, 16'h1000, mk(3'd4, 16'h0000, 0, 0, 2'd0));
    cyc(1, 0, 0, 0, 16'h1000, mk(3'd4, 16'h0000, 0, 0, 2'd0));
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 16'h1000, mk(3'd4, 16'h0000, 0, 0, 2'd0));
    cyc(0, 0, 0, 0, 16'h1000, mk(3'd0, 16'h1000, 1, 0, 2'd0));

    // Warning halves the amplitude, including odd inputs; release returns.
    cyc(0, 0, 1, 0, 16'h1000, mk(3'd1, 16'h0800, 1, 0, 2'd0));
    cyc(0, 0, 1, 0, 16'h1235, mk(3'd1, 16'h091A, 1, 0, 2'd0));
    cyc(0, 0, 0, 0, 16'h1000, mk(3'd0, 16'h1000, 1, 0, 2'd0));

    // Trigger ramp from 0x0400; clear and amp_in changes are ignored mid-ramp.
    cyc(0, 0, 0, 0, 16'h0400, mk(3'd0, 16'h0400, 1, 0, 2'd0));
    cyc(0, 1, 0, 0, 16'h0400, mk(3'd2, 16'h0400, 1, 1, 2'd1));
    cyc(0, 0, 0, 1, 16'hFFFF, mk(3'd2, 16'h0300, 1, 1, 2'd1));
    cyc(0, 1, 1, 0, 16'hFFFF, mk(3'd2, 16'h0200, 1, 1, 2'd1));
    cyc(0, 0, 0, 0, 16'hFFFF, mk(3'd2, 16'h0100, 1, 1, 2'd1));
    cyc(0, 0, 0, 0, 16'hFFFF, mk(3'd3, 16'h0000, 0, 1, 2'd1));

    // Clear while still triggered is ignored; clean clear enters holdoff.
    cyc(0, 1, 0, 1, 16'h0400, mk(3'd3, 16'h0000, 0, 1, 2'd1));
    cyc(0, 0, 0, 0, 16'h0400, mk(3'd3, 16'h0000, 0, 1, 2'd1));
    cyc(0, 0, 0, 1, 16'h0400, mk(3'd4, 16'h0000, 0, 0, 2'd1));
    cyc(0, 0, 0, 0, 16'h0400, mk(3'd4, 16'h0000, 0, 0, 2'd1));
    cyc(0, 1, 0, 0, 16'h0400, mk(3'd3, 16'h0000, 0, 1, 2'd2));
    cyc(0, 0, 0, 0, 16'h0400, mk(3'd3, 16'h0000, 0, 1, 2'd2));

    // Saturation: repeated clear/trigger pairs, count sticks at 3.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, 16'h0400, mk(3'd4, 16'h0000, 0, 0, 2'd2 + ((i == 0) ? 2'd0 : 2'd1)));
      cyc(0, 1, 0, 0, 16'h0400, mk(3'd3, 16'h0000, 0, 1, 2'd3));
    end
    // Fifth pair: trigger lands on the holdoff expiry cycle and wins.
    cyc(0, 0, 0, 1, 16'h0400, mk(3'd4, 16'h0000, 0, 0, 2'd3));
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 16'h0400, mk(3'd4, 16'h0000, 0, 0, 2'd3));
    cyc(0, 1, 0, 0, 16'h0400, mk(3'd3, 16'h0000, 0, 1, 2'd3));

    // Recover to NORMAL at 0x0100; warning+trigger ramps, exact-step goes to SAFE.
    cyc(0, 0, 0, 1, 16'h0100, mk(3'd4, 16'h0000, 0, 0, 2'd3));
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 16'h0100, mk(3'd4, 16'h0000, 0, 0, 2'd3));
    cyc(0, 0, 0, 0, 16'h0100, mk(3'd0, 16'h0100, 1, 0, 2'd3));
    cyc(0, 1, 1, 0, 16'h0100, mk(3'd2, 16'h0100, 1, 1, 2'd3));
    cyc(0, 0, 0, 0, 16'h0100, mk(3'd3, 16'h0000, 0, 1, 2'd3));

    // Mid-ramp reset at amp_out=0x0300, then holdoff back to NORMAL.
    cyc(0, 0, 0, 1, 16'h0400, mk(3'd4, 16'h0000, 0, 0, 2'd3));
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 16'h0400, mk(3'd4, 16'h0000, 0, 0, 2'd3));
    cyc(0, 0, 0, 0, 16'h0400, mk(3'd0, 16'h0400, 1, 0, 2'd3));
    cyc(0, 1, 0, 0, 16'h0400, mk(3'd2, 16'h0400, 1, 1, 2'd3));
    cyc(0, 0, 0, 0, 16'h0400, mk(3'd2, 16'h0300, 1, 1, 2'd3));
    cyc(1, 1, 1, 1, 16'h0400, mk(3'd4, 16'h0000, 0, 0, 2'd0));
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 16'h0777, mk(3'd4, 16'h0000, 0, 0, 2'd0));
    cyc(0, 0, 0, 0, 16'h0777, mk(3'd0, 16'h0777, 1, 0, 2'd0));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
